// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level sequencer for the LED-matrix rhythm game.
// It debounces the three player buttons, walks MENU -> COUNTDOWN -> PLAY ->
// RESULT, keeps the confirmed song index, paces the note shifter with a
// one-cycle step strobe and clears the score when a song starts.
// The phase register is driven straight onto the state port, so the FSM is
// always observable from outside the block.
module game_flow_ctrl #(
    parameter int DEB_CYC     = 16,
    parameter int STEP_DIV    = 12500,
    parameter int COUNT_DIV   = 50000,
    parameter int RESULT_HOLD = 25000,
    parameter int NUM_SONGS   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       red_button,
    input  logic       blue_button,
    input  logic       yellow_button,
    input  logic       finish,
    output logic [1:0] state,
    output logic [1:0] song_confirm,
    output logic       step,
    output logic       score_clear,
    output logic [1:0] countdown,
    output logic       paused
);

    localparam logic [1:0] S_MENU      = 2'd0;
    localparam logic [1:0] S_COUNTDOWN = 2'd1;
    localparam logic [1:0] S_PLAY      = 2'd2;
    localparam logic [1:0] S_RESULT    = 2'd3;

    // Debounce counter only has to reach DEB_CYC-1.
    localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

    // One divider is shared by countdown, note pacing and result hold, since
    // only one of them is ever active; size it for the largest user.
    localparam int DIV_A   = (STEP_DIV > COUNT_DIV) ? STEP_DIV : COUNT_DIV;
    localparam int DIV_MAX = (DIV_A > RESULT_HOLD) ? DIV_A : RESULT_HOLD;
    localparam int DIV_W   = $clog2(DIV_MAX + 1);
    localparam logic [DIV_W-1:0] STEP_LAST  = DIV_W'(STEP_DIV - 1);
    localparam logic [DIV_W-1:0] COUNT_LAST = DIV_W'(COUNT_DIV - 1);
    localparam logic [DIV_W-1:0] HOLD_END   = DIV_W'(RESULT_HOLD);

    localparam logic [1:0] LAST_SONG = 2'(NUM_SONGS - 1);

    // Button lanes: bit 0 red, bit 1 blue, bit 2 yellow.
    logic [2:0]       raw;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       deb;
    logic [2:0]       press;
    logic [DEB_W-1:0] deb_cnt [3];
    logic [DIV_W-1:0] div_cnt;

    logic press_red;
    logic press_blue;
    logic press_yellow;

    assign raw          = {yellow_button, blue_button, red_button};
    assign press_red    = press[0];
    assign press_blue   = press[1];
    assign press_yellow = press[2];

    // Synchronize each button, accept a new level only after DEB_CYC agreeing
    // samples, and emit a registered one-cycle pulse on the accepted rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            press <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= '0;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= sync2[i];
                        press[i]   <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Game phase sequencer; step and score_clear default low so they can only
    // ever be single-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_MENU;
            song_confirm <= 2'd0;
            step         <= 1'b0;
            score_clear  <= 1'b0;
            countdown    <= 2'd0;
            paused       <= 1'b0;
            div_cnt      <= '0;
        end else begin
            step        <= 1'b0;
            score_clear <= 1'b0;
            case (state)
                S_MENU: begin
                    // Yellow confirms and wins over any simultaneous red/blue.
                    if (press_yellow) begin
                        state       <= S_COUNTDOWN;
                        score_clear <= 1'b1;
                        countdown   <= 2'd3;
                        div_cnt     <= '0;
                    end else if (press_red && !press_blue) begin
                        song_confirm <= (song_confirm == 2'd0) ? LAST_SONG
                                                               : song_confirm - 2'd1;
                    end else if (press_blue && !press_red) begin
                        song_confirm <= (song_confirm == LAST_SONG) ? 2'd0
                                                                    : song_confirm + 2'd1;
                    end
                end
                S_COUNTDOWN: begin
                    if (press_yellow) begin
                        state     <= S_MENU;
                        countdown <= 2'd0;
                        div_cnt   <= '0;
                    end else if (div_cnt == COUNT_LAST) begin
                        div_cnt <= '0;
                        if (countdown == 2'd1) begin
                            state     <= S_PLAY;
                            countdown <= 2'd0;
                        end else begin
                            countdown <= countdown - 2'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_PLAY: begin
                    // Song end beats a pause toggle and swallows a coincident step.
                    if (finish) begin
                        state   <= S_RESULT;
                        paused  <= 1'b0;
                        div_cnt <= '0;
                    end else if (press_yellow) begin
                        paused <= ~paused;
                    end else if (!paused) begin
                        if (div_cnt == STEP_LAST) begin
                            div_cnt <= '0;
                            step    <= 1'b1;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                end
                S_RESULT: begin
                    // The divider doubles as the hold counter and parks at HOLD_END.
                    if (press_yellow && div_cnt == HOLD_END) begin
                        state   <= S_MENU;
                        div_cnt <= '0;
                    end else if (div_cnt != HOLD_END) begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_MENU;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Testbench for game_flow_ctrl with small timing parameters. Inputs are driven
// on the falling edge and outputs sampled there too, so every sample sits half
// a period away from the active rising edge.
module tb_game_flow_ctrl;

    localparam int DEB = 4;
    localparam int SD  = 10;
    localparam int CD  = 20;
    localparam int RH  = 8;
    localparam int NS  = 3;

    // A raw rise driven at a falling edge becomes a phase action on the 7th
    // rising edge after it: 2 synchronizer edges + DEB samples + 1 register.
    localparam int LAT = 2 + DEB + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       red;
    logic       blue;
    logic       yellow;
    logic       fin;
    logic [1:0] state;
    logic [1:0] song;
    logic       step;
    logic       score_clear;
    logic [1:0] countdown;
    logic       paused;

    int         total = 0;
    int         bad   = 0;
    int         song_pos = 0;
    logic [1:0] exp_song;

    game_flow_ctrl #(
        .DEB_CYC     (DEB),
        .STEP_DIV    (SD),
        .COUNT_DIV   (CD),
        .RESULT_HOLD (RH),
        .NUM_SONGS   (NS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .red_button    (red),
        .blue_button   (blue),
        .yellow_button (yellow),
        .finish        (fin),
        .state         (state),
        .song_confirm  (song),
        .step          (step),
        .score_clear   (score_clear),
        .countdown     (countdown),
        .paused        (paused)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not reach its summary in time");
        $fatal(1, "watchdog expired");
    end

    // Driver helpers (called at a falling edge)
    task automatic press(input logic r, input logic b, input logic y);
        red = r; blue = b; yellow = y;
        repeat (LAT) @(negedge clk);
    endtask

    task automatic release_all();
        red = 1'b0; blue = 1'b0; yellow = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    function automatic bit in_win(input int p, input int e);
        return (p >= e - LAT) && (p <= e);
    endfunction

    task automatic test_reset();
        rst = 1'b1; red = 1'b0; blue = 1'b0; yellow = 1'b0; fin = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
        total++; if (song !== 2'd0) begin bad++; $display("FAIL reset_song got=%0d want=0", song); end
        total++; if (step !== 1'b0) begin bad++; $display("FAIL reset_step got=%0b want=0", step); end
        total++; if (score_clear !== 1'b0) begin bad++; $display("FAIL reset_score_clear got=%0b want=0", score_clear); end
        total++; if (countdown !== 2'd0) begin bad++; $display("FAIL reset_countdown got=%0d want=0", countdown); end
        total++; if (paused !== 1'b0) begin bad++; $display("FAIL reset_paused got=%0b want=0", paused); end
        rst = 1'b0;
        song_pos = 0;
        exp_song = 2'd0;
        repeat (2) @(negedge clk);
        total++; if (state !== 2'd0) begin bad++; $display("FAIL idle_state got=%0d want=0", state); end
    endtask

    task automatic test_bounce();
        int ce;
        yellow = 1'b1; @(negedge clk);
        yellow = 1'b0; @(negedge clk);
        yellow = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            total++;
            if (state !== ((i >= LAT) ? 2'd1 : 2'd0)) begin
                bad++; $display("FAIL bounce_state i=%0d got=%0d want=%0d", i, state, (i >= LAT) ? 1 : 0);
            end
            total++;
            if (score_clear !== (i == LAT)) begin
                bad++; $display("FAIL bounce_score_clear i=%0d got=%0b want=%0b", i, score_clear, i == LAT);
            end
        end
        total++; if (countdown !== 2'd3) begin bad++; $display("FAIL bounce_countdown got=%0d want=3", countdown); end
        // Countdown cycle index is now 1; release brings it to 9.
        release_all();
        ce = int'($urandom_range(27, 39));
        repeat (ce - LAT - 9) @(negedge clk);
        total++; if (countdown !== 2'd2) begin bad++; $display("FAIL abort_pre_countdown got=%0d want=2", countdown); end
        press(1'b0, 1'b0, 1'b1);
        total++; if (state !== 2'd0) begin bad++; $display("FAIL abort_state got=%0d want=0", state); end
        total++; if (countdown !== 2'd0) begin bad++; $display("FAIL abort_countdown got=%0d want=0", countdown); end
        total++; if (song !== exp_song) begin bad++; $display("FAIL abort_song got=%0d want=%0d", song, exp_song); end
        release_all();
    endtask

    task automatic test_menu();
        int kinds[$];
        kinds.push_back(0);   // red
        kinds.push_back(1);   // blue
        kinds.push_back(1);
        kinds.push_back(2);   // red and blue together
        for (int i = 0; i < 6; i++) kinds.push_back(int'($urandom_range(0, 2)));
        foreach (kinds[i]) begin
            case (kinds[i])
                0: begin press(1'b1, 1'b0, 1'b0); song_pos = (song_pos + NS - 1) % NS; end
                1: begin press(1'b0, 1'b1, 1'b0); song_pos = (song_pos + 1) % NS; end
                default: press(1'b1, 1'b1, 1'b0);
            endcase
            exp_song = 2'(song_pos);
            total++;
            if (song !== exp_song) begin
                bad++; $display("FAIL menu_song step=%0d kind=%0d got=%0d want=%0d", i, kinds[i], song, exp_song);
            end
            total++; if (state !== 2'd0) begin bad++; $display("FAIL menu_state step=%0d got=%0d want=0", i, state); end
            release_all();
        end
        // Yellow together with blue: confirm wins, song untouched.
        press(1'b0, 1'b1, 1'b1);
        total++; if (state !== 2'd1) begin bad++; $display("FAIL confirm_state got=%0d want=1", state); end
        total++; if (song !== exp_song) begin bad++; $display("FAIL confirm_song got=%0d want=%0d", song, exp_song); end
    endtask

    // Entered at the first COUNTDOWN sample; leaves at the first PLAY sample.
    task automatic test_countdown();
        logic [1:0] es;
        logic [1:0] ec;
        for (int c = 0; c <= 3 * CD; c++) begin
            if (c > 0) @(negedge clk);
            es = (c < 3 * CD) ? 2'd1 : 2'd2;
            ec = (c < 3 * CD) ? 2'(3 - c / CD) : 2'd0;
            total++; if (state !== es) begin bad++; $display("FAIL cd_state c=%0d got=%0d want=%0d", c, state, es); end
            total++; if (countdown !== ec) begin bad++; $display("FAIL cd_digit c=%0d got=%0d want=%0d", c, countdown, ec); end
            total++; if (score_clear !== (c == 0)) begin bad++; $display("FAIL cd_score_clear c=%0d got=%0b want=%0b", c, score_clear, c == 0); end
            total++; if (step !== 1'b0) begin bad++; $display("FAIL cd_step c=%0d got=%0b want=0", c, step); end
            // Red and blue presses land inside the countdown and must be ignored.
            red    = (c >= 10 && c < 18);
            blue   = (c >= 30 && c < 38);
            yellow = 1'b0;
        end
        total++; if (song !== exp_song) begin bad++; $display("FAIL cd_song got=%0d want=%0d", song, exp_song); end
    endtask

    // Pause at edge e1, resume len edges later, finish at edge f, yellow in
    // RESULT at f+k1 and optionally f+k2 (k2 = 0 means none).
    task automatic test_play_result(input int e1, input int len, input int f, input int k1, input int k2);
        int         e2;
        int         h;
        int         last;
        logic [15:0] exp_q[$];
        logic [1:0] es;
        logic       ep;
        logic       ex;
        e2 = e1 + len;
        h = -1;
        if (k1 > RH) h = f + k1;
        else if (k2 > RH) h = f + k2;
        last = ((k2 > 0) ? f + k2 : f + k1) + 3;
        // Running cycles before the pause press are e1-1; steps fall on every
        // SD-th running cycle, and finish swallows a step on its own edge.
        for (int t = SD; t <= e1 - 1; t += SD) exp_q.push_back(16'(t));
        for (int t = SD; e2 + t - (e1 - 1) < f; t += SD)
            if (t > e1 - 1) exp_q.push_back(16'(e2 + t - (e1 - 1)));
        for (int p = 0; p <= last; p++) begin
            if (p > 0) @(negedge clk);
            es = (p < f) ? 2'd2 : ((h >= 0 && p >= h) ? 2'd0 : 2'd3);
            ep = (p >= e1 && p < e2 && p < f);
            ex = (exp_q.size() > 0 && exp_q[0] == 16'(p));
            total++; if (state !== es) begin bad++; $display("FAIL play_state p=%0d got=%0d want=%0d", p, state, es); end
            total++; if (paused !== ep) begin bad++; $display("FAIL play_paused p=%0d got=%0b want=%0b", p, paused, ep); end
            total++; if (step !== ex) begin bad++; $display("FAIL play_step p=%0d got=%0b want=%0b", p, step, ex); end
            if (ex) void'(exp_q.pop_front());
            yellow = in_win(p, e1) || in_win(p, e2) || in_win(p, f + k1) || (k2 > 0 && in_win(p, f + k2));
            fin    = (p >= f - 1) && (p < f + 4);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL play_steps_left got=%0d want=0", exp_q.size()); end
        total++; if (song !== exp_song) begin bad++; $display("FAIL result_song got=%0d want=%0d", song, exp_song); end
        fin = 1'b0;
        release_all();
    endtask

    task automatic test_pause_finish();
        int len;
        len = int'($urandom_range(16, 30));
        // Finish lands on the edge of the 40th running cycle, where a step is due.
        test_play_result(26, len, 26 + len + 40 - 25, 3, int'($urandom_range(18, 25)));
    endtask

    task automatic test_back_to_back();
        int e1;
        int len;
        e1  = int'($urandom_range(22, 35));
        len = int'($urandom_range(16, 30));
        press(1'b0, 1'b0, 1'b1);
        test_countdown();
        test_play_result(e1, len, e1 + len + int'($urandom_range(12, 30)), RH + 1, 0);
    endtask

    task automatic test_async_reset();
        press(1'b0, 1'b0, 1'b1);
        test_countdown();
        repeat (int'($urandom_range(5, 40))) @(negedge clk);
        total++; if (state !== 2'd2) begin bad++; $display("FAIL pre_reset_state got=%0d want=2", state); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (state !== 2'd0) begin bad++; $display("FAIL areset_state got=%0d want=0", state); end
        total++; if (song !== 2'd0) begin bad++; $display("FAIL areset_song got=%0d want=0", song); end
        total++; if (step !== 1'b0) begin bad++; $display("FAIL areset_step got=%0b want=0", step); end
        total++; if (score_clear !== 1'b0) begin bad++; $display("FAIL areset_score_clear got=%0b want=0", score_clear); end
        total++; if (countdown !== 2'd0) begin bad++; $display("FAIL areset_countdown got=%0d want=0", countdown); end
        total++; if (paused !== 1'b0) begin bad++; $display("FAIL areset_paused got=%0b want=0", paused); end
        @(negedge clk);
        rst = 1'b0;
        song_pos = 0;
        exp_song = 2'd0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            total++; if (state !== 2'd0) begin bad++; $display("FAIL post_reset_state i=%0d got=%0d want=0", i, state); end
            total++; if (step !== 1'b0) begin bad++; $display("FAIL post_reset_step i=%0d got=%0b want=0", i, step); end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_menu();
        test_countdown();
        test_pause_finish();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
